// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, default sizing
// and the mmio register offsets.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int BAUD_DIV_DEF   = 868;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int DATA_W_DEF     = 8;

    localparam logic [7:0] UART_TX_DATA_OFS = 8'h00;
    localparam logic [7:0] UART_TX_STAT_OFS = 8'h04;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// mmio-facing bundle of the UART TX peripheral:
// write strobe, overflow clear and the polled status.
interface uart_tx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;
    logic               ovf_clr;
    logic               tx_busy;
    logic               tx_empty;
    logic               tx_full;
    logic [LEVEL_W-1:0] tx_level;
    logic               overflow;

    modport master (
        output wr_en, wr_data, ovf_clr,
        input  tx_busy, tx_empty, tx_full, tx_level, overflow
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output tx_busy, tx_empty, tx_full, tx_level, overflow
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock circular FIFO with occupancy count.
// A push while full is taken only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter behind the mmio decoder.
// Bytes queue in sync_fifo and are shifted out LSB first on txd.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus,
    output logic          txd
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              ovf_q;
    logic              pop;
    logic              last;
    logic              drop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.wr_en),
        .din   (bus.wr_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign last = cnt_q == CNT_W'(BAUD_DIV - 1);
    assign drop = bus.wr_en && fifo_full && !pop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (state_q != IDLE) cnt_d = last ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_W - 1)) state_d = STOP;
                    else idx_d = idx_q + 1'b1;
                end
            end
            STOP: begin
                // chain straight into the next start bit when data is waiting
                if (last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign txd = (state_q == START) ? 1'b0 :
                 (state_q == DATA)  ? shift_q[0] : 1'b1;

    assign bus.tx_busy  = state_q != IDLE;
    assign bus.tx_empty = fifo_empty;
    assign bus.tx_full  = fifo_full;
    assign bus.tx_level = fifo_level;
    assign bus.overflow = ovf_q;

endmodule
